// File: rtl/branch_offset_encoder.sv
// Maps a PC-relative offset to the lowest index of a writable 8-entry table by sequential scan.
// One entry per cycle: hit at i answers i+1 cycles after acceptance, miss after 8; result held until RspReady.
module branch_offset_encoder #(
   parameter int W = 10
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         WrEn,
   input  logic [2:0]   WrAddr,
   input  logic [W-1:0] WrData,
   input  logic         ReqValid,
   output logic         ReqReady,
   input  logic [W-1:0] ReqTarget,
   output logic         RspValid,
   input  logic         RspReady,
   output logic [2:0]   RspAddr,
   output logic         RspHit
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   // Reset contents are signed offsets, sign-extended to whatever W is chosen.
   localparam logic [W-1:0] RST_TAB [8] = '{
      W'(2), W'(-5), W'(-6), W'(-7), W'(-8), W'(-13), W'(-14), W'(-17)
   };

   state_t       state_q, state_d;
   logic [2:0]   idx_q, idx_d;
   logic [W-1:0] target_q, target_d;
   logic [2:0]   addr_q, addr_d;
   logic         hit_q, hit_d;
   logic [W-1:0] tab_q [8];
   logic [W-1:0] tab_d [8];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      target_d = target_q;
      addr_d   = addr_q;
      hit_d    = hit_q;
      tab_d    = tab_q;
      if (WrEn) begin
         tab_d[WrAddr] = WrData;
      end
      // The scan compares against tab_q, so a same-cycle write to the entry under test is not seen.
      case (state_q)
         IDLE: begin
            if (ReqValid) begin
               target_d = ReqTarget;
               idx_d    = 3'd0;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            if (tab_q[idx_q] == target_q) begin
               addr_d  = idx_q;
               hit_d   = 1'b1;
               state_d = RESP;
            end else if (idx_q == 3'd7) begin
               addr_d  = 3'd0;
               hit_d   = 1'b0;
               state_d = RESP;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         RESP: begin
            if (RspReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         idx_q    <= 3'd0;
         target_q <= '0;
         addr_q   <= 3'd0;
         hit_q    <= 1'b0;
         tab_q    <= RST_TAB;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         target_q <= target_d;
         addr_q   <= addr_d;
         hit_q    <= hit_d;
         tab_q    <= tab_d;
      end
   end

   assign ReqReady = (state_q == IDLE);
   assign RspValid = (state_q == RESP);
   assign RspAddr  = addr_q;
   assign RspHit   = hit_q;

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Directed bench for branch_offset_encoder with a queue of expected responses.
module tb_branch_offset_encoder;

   logic       Clk;
   logic       Reset;
   logic       WrEn;
   logic [2:0] WrAddr;
   logic [9:0] WrData;
   logic       ReqValid;
   logic       ReqReady;
   logic [9:0] ReqTarget;
   logic       RspValid;
   logic       RspReady;
   logic [2:0] RspAddr;
   logic       RspHit;

   branch_offset_encoder #(.W(10)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .WrEn      (WrEn),
      .WrAddr    (WrAddr),
      .WrData    (WrData),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .ReqTarget (ReqTarget),
      .RspValid  (RspValid),
      .RspReady  (RspReady),
      .RspAddr   (RspAddr),
      .RspHit    (RspHit)
   );

   typedef struct {
      logic [2:0] addr;
      logic       hit;
      int         lat;
   } exp_t;

   exp_t sbq [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [9:0] d);
      WrEn = 1'b1; WrAddr = a; WrData = d;
      @(posedge Clk); #1;
      WrEn = 1'b0;
   endtask

   // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
   task automatic accept(input logic [9:0] tgt);
      chk("req_ready_idle", ReqReady, 1'b1);
      ReqValid = 1'b1; ReqTarget = tgt;
      @(posedge Clk); #1;
      acc_cyc = cyc;
      ReqValid = 1'b0;
      ReqTarget = ~tgt;
   endtask

   task automatic issue(input logic [9:0] tgt, input logic [2:0] ea, input logic eh, input int el);
      exp_t e;
      e.addr = ea; e.hit = eh; e.lat = el;
      sbq.push_back(e);
      accept(tgt);
   endtask

   task automatic wait_rsp(input int hold);
      exp_t e;
      if (sbq.size() == 0) begin
         chk("sb_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sbq.pop_front();
      for (int k = 0; k < 12 && RspValid !== 1'b1; k++) begin
         @(posedge Clk); #1;
      end
      chk("rsp_latency", cyc - acc_cyc, e.lat);
      chk("rsp_addr", RspAddr, e.addr);
      chk("rsp_hit", RspHit, e.hit);
      for (int h = 0; h < hold; h++) begin
         ReqValid = 1'b1; ReqTarget = 10'h3f8;
         @(posedge Clk); #1;
         chk("hold_vld", RspValid, 1'b1);
         chk("hold_addr", RspAddr, e.addr);
         chk("hold_hit", RspHit, e.hit);
         chk("hold_req_ready", ReqReady, 1'b0);
      end
      ReqValid = 1'b0;
      RspReady = 1'b1;
      @(posedge Clk); #1;
      RspReady = 1'b0;
      chk("release_req_ready", ReqReady, 1'b1);
      chk("release_rsp_vld", RspValid, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; WrEn = 1'b0; WrAddr = 3'd0; WrData = 10'h0;
      ReqValid = 1'b0; ReqTarget = 10'h0; RspReady = 1'b0;
      @(posedge Clk); #1;
      chk("rst_req_ready", ReqReady, 1'b1);
      chk("rst_rsp_vld", RspValid, 1'b0);
      chk("rst_rsp_addr", RspAddr, 3'd0);
      chk("rst_rsp_hit", RspHit, 1'b0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      // Lookups against the reset table
      issue(10'h3f8, 3'd4, 1'b1, 5); wait_rsp(0);
      issue(10'h001, 3'd0, 1'b0, 8); wait_rsp(0);
      issue(10'h002, 3'd0, 1'b1, 1); wait_rsp(0);
      issue(10'h3ef, 3'd7, 1'b1, 8); wait_rsp(0);
      issue(10'h3fb, 3'd1, 1'b1, 2); wait_rsp(0);

      // Lowest index wins; a later write can expose a higher one
      wr(3'd6, 10'h002);
      issue(10'h002, 3'd0, 1'b1, 1); wait_rsp(0);
      wr(3'd0, 10'h010);
      issue(10'h002, 3'd6, 1'b1, 7); wait_rsp(0);

      // Backpressure on the response with requests offered meanwhile
      issue(10'h3f3, 3'd5, 1'b1, 6); wait_rsp(3);

      // Reset in the middle of a scan, after corrupting entry 2
      wr(3'd2, 10'h123);
      accept(10'h1ff);
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b1;
      #1;
      chk("midscan_rst_req_ready", ReqReady, 1'b1);
      chk("midscan_rst_rsp_vld", RspValid, 1'b0);
      chk("midscan_rst_addr", RspAddr, 3'd0);
      chk("midscan_rst_hit", RspHit, 1'b0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      issue(10'h3fa, 3'd2, 1'b1, 3); wait_rsp(0);
      issue(10'h3f2, 3'd6, 1'b1, 7); wait_rsp(0);
      issue(10'h002, 3'd0, 1'b1, 1); wait_rsp(0);

      // Writes during a scan: same-entry write compares old value, later entries see new value
      issue(10'h077, 3'd3, 1'b1, 4);
      WrEn = 1'b1; WrAddr = 3'd0; WrData = 10'h077;
      @(posedge Clk); #1;
      WrAddr = 3'd3;
      @(posedge Clk); #1;
      WrEn = 1'b0;
      wait_rsp(0);
      issue(10'h077, 3'd0, 1'b1, 1); wait_rsp(0);

      // Neither writes nor requests take effect while reset is held
      Reset = 1'b1;
      WrEn = 1'b1; WrAddr = 3'd1; WrData = 10'h002;
      ReqValid = 1'b1; ReqTarget = 10'h3f8;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_hold_req_ready", ReqReady, 1'b1);
      chk("rst_hold_rsp_vld", RspValid, 1'b0);
      WrEn = 1'b0; ReqValid = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      chk("post_rst_rsp_vld", RspValid, 1'b0);
      issue(10'h3fb, 3'd1, 1'b1, 2); wait_rsp(0);
      issue(10'h3f9, 3'd3, 1'b1, 4); wait_rsp(1);

      chk("sb_empty", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_offset_encoder.md
BRANCH_OFFSET_ENCODER -- requirements
Module: branch_offset_encoder

Interface
REQ-001 SHALL have parameter W, default 10, meaning the width of a PC-relative offset entry in two's complement.
REQ-002 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port WrEn  input  1  table write strobe.
REQ-005 SHALL have port WrAddr  input  3  table entry index to write.
REQ-006 SHALL have port WrData  input  W  offset value to write.
REQ-007 SHALL have port ReqValid  input  1  offset-lookup request valid.
REQ-008 SHALL have port ReqReady  output  1  block can accept a request.
REQ-009 SHALL have port ReqTarget  input  W  offset to encode into a 3-bit index.
REQ-010 SHALL have port RspValid  output  1  result valid.
REQ-011 SHALL have port RspReady  input  1  consumer accepts result.
REQ-012 SHALL have port RspAddr  output  3  matching table index.
REQ-013 SHALL have port RspHit  output  1  1 = match found, 0 = no entry equals ReqTarget.

Function
REQ-014 SHALL hold an 8-entry x W-bit table; on reset the entries are 0:10'h002, 1:10'h3fb, 2:10'h3fa, 3:10'h3f9, 4:10'h3f8, 5:10'h3f3, 6:10'h3f2, 7:10'h3ef.
REQ-015 SHALL write WrData into entry WrAddr at the clock edge when WrEn=1, in any FSM state.
REQ-016 SHALL implement FSM states IDLE, SCAN, RESP; reset state IDLE.
REQ-017 SHALL drive ReqReady=1 only in IDLE; RspValid=1 only in RESP.
REQ-018 IDLE: on ReqValid&ReqReady, SHALL capture ReqTarget, clear the scan index to 0, and go to SCAN.
REQ-019 SCAN: each cycle SHALL compare table[index] with the captured target (full W-bit equality), one entry per cycle, index ascending.
REQ-020 SCAN: on a match SHALL register RspAddr=index, RspHit=1 and go to RESP; the lowest matching index wins.
REQ-021 SCAN: on no match with index=7 SHALL register RspAddr=0, RspHit=0 and go to RESP; index never wraps past 7.
REQ-022 Latency: match at index i SHALL raise RspValid i+1 cycles after the accepting edge; a miss SHALL raise RspValid 8 cycles after it.
REQ-023 RESP: RspAddr/RspHit SHALL stay stable while RspValid=1 and RspReady=0; on RspValid&RspReady SHALL return to IDLE (ReqReady=1 the next cycle).
REQ-024 A write and a compare on the same entry in the same cycle SHALL compare against the pre-write value; writes to not-yet-scanned entries SHALL be visible to the ongoing scan.
REQ-025 ReqTarget changes after acceptance SHALL not affect the ongoing scan.
REQ-026 SHALL ignore ReqValid outside IDLE (no queuing).

Reset
REQ-027 Reset=1 SHALL immediately (asynchronously) force IDLE, ReqReady=1, RspValid=0, RspAddr=0, RspHit=0, and restore the REQ-014 table contents, including mid-scan or mid-response.
REQ-028 SHALL accept no request and perform no write while Reset=1.

Verification
REQ-029 After reset, request 10'h3f8 -> RspValid 5 cycles after acceptance, RspAddr=4, RspHit=1.
REQ-030 After reset, request 10'h002 -> RspValid 1 cycle after acceptance, RspAddr=0, RspHit=1; request 10'h001 -> RspValid after 8 cycles, RspAddr=0, RspHit=0.
REQ-031 Write entry 6 = 10'h002, request 10'h002 -> RspAddr=0; then write entry 0 = 10'h010, request 10'h002 -> RspAddr=6, RspHit=1.
REQ-032 Hold RspReady=0 for 3 cycles in RESP -> RspValid, RspAddr, RspHit held, ReqReady=0 and ReqValid ignored; RspReady=1 -> IDLE next cycle.
REQ-033 Assert Reset during SCAN at index 3 after writing entry 2 = 10'h123 -> RspValid=0, ReqReady=1 at once; entry 2 reads back as 10'h3fa (request 10'h3fa -> RspAddr=2).
